ff_debounce_edge: RTL

Input-conditioning stage that consumes the single-bit output of the posedge flip-flop and turns it into a clean, debounced level plus one-cycle edge pulses. The block synchronises the bit and accepts a level change only after it has held for a programmable number of clocks. Its outputs drive edge-triggered control logic downstream.

---
 rtl/ff_pkg.sv | 19 +
 rtl/ff_sync_chain.sv | 39 +++
 rtl/ff_debounce_edge.sv | 109 ++++++++++
 3 files changed

// File: rtl/ff_pkg.sv
// Shared definitions for the flip-flop conditioning library: the debounce
// FSM state encoding and the counter-width helper.
package ff_pkg;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } deb_state_t;

    // Width of a counter that must represent 0..n (at least one bit).
    function automatic int cnt_width(input int n);
        if (n < 1) begin
            return 1;
        end else begin
            return $clog2(n + 1);
        end
    endfunction

endpackage

// File: rtl/ff_sync_chain.sv
// Multi-stage synchroniser: shifts d through STAGES registers; q is the
// last stage. All stages load INIT on a synchronous reset.
module ff_sync_chain #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_r;

    generate
        if (STAGES == 1) begin : g_single
            // Single register stage, synchronous reset to INIT.
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_r <= INIT;
                end else begin
                    stage_r <= d;
                end
            end
        end else begin : g_multi
            // Shift register, newest sample enters at bit 0.
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_r <= {STAGES{INIT}};
                end else begin
                    stage_r <= {stage_r[STAGES-2:0], d};
                end
            end
        end
    endgenerate

    assign q = stage_r[STAGES-1];

endmodule

// File: rtl/ff_debounce_edge.sv
// Debounce and edge detector: synchronises D, accepts a level change only
// after it has held for DEBOUNCE_CYCLES consecutive clocks, and emits
// one-cycle rise/fall pulses on each accepted change.
module ff_debounce_edge
    import ff_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic INIT            = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic D,
    output logic Q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    logic          sync_s;
    deb_state_t    state_r;
    logic [CW-1:0] cnt_r;
    logic          q_r;
    logic          rise_r;
    logic          fall_r;
    logic          busy_r;

    ff_sync_chain #(
        .STAGES (SYNC_STAGES),
        .INIT   (INIT)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (D),
        .q   (sync_s)
    );

    // Debounce FSM, qualification counter and registered level/pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_STABLE;
            cnt_r   <= CNT_ZERO;
            q_r     <= INIT;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless a toggle below re-arms one.
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            case (state_r)
                ST_STABLE: begin
                    if (sync_s != q_r) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            // No qualification window: accept immediately.
                            q_r     <= ~q_r;
                            rise_r  <= ~q_r;
                            fall_r  <= q_r;
                            cnt_r   <= CNT_ZERO;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= ST_PENDING;
                            cnt_r   <= CNT_ONE;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        cnt_r  <= CNT_ZERO;
                        busy_r <= 1'b0;
                    end
                end
                ST_PENDING: begin
                    if (sync_s == q_r) begin
                        // Bounce back to the current level: drop the candidate.
                        state_r <= ST_STABLE;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b0;
                    end else if (cnt_r == CNT_LAST) begin
                        // Held long enough: accept the new level.
                        q_r     <= ~q_r;
                        rise_r  <= ~q_r;
                        fall_r  <= q_r;
                        state_r <= ST_STABLE;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r  <= cnt_r + CNT_ONE;
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_STABLE;
                    cnt_r   <= CNT_ZERO;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign Q    = q_r;
    assign rise = rise_r;
    assign fall = fall_r;
    assign busy = busy_r;

endmodule
